// File: rtl/mano_io_term_if.sv
// mano_io_term_if -- signal bundle between the Mano CPU I/O registers and the
// serial terminal device.
//
//   outr         CPU OUTR register value              (CPU -> device)
//   fgo          CPU FGO flag, 0 = character pending  (CPU -> device)
//   fgo_set      one-cycle pulse, CPU loads FGO=1     (device -> CPU)
//   fgi          CPU FGI flag, 1 = INPR not consumed  (CPU -> device)
//   fgi_set      one-cycle pulse, CPU loads FGI=1     (device -> CPU)
//   inpr_data    received character for INPR          (device -> CPU)
//   inpr_ld      one-cycle pulse, CPU loads INPR      (device -> CPU)
//   txd          serial out, idle high, 8N1           (device -> line)
//   rxd          serial in, asynchronous, 8N1         (line -> device)
//   rx_overrun   sticky, character dropped (fgi=1)    (device -> CPU)
//   rx_frame_err sticky, stop bit sampled low         (device -> CPU)
//
// The master modport is the CPU/line side, the slave modport is the device.
interface mano_io_term_if;
    logic [7:0] outr;
    logic       fgo;
    logic       fgo_set;
    logic       fgi;
    logic       fgi_set;
    logic [7:0] inpr_data;
    logic       inpr_ld;
    logic       txd;
    logic       rxd;
    logic       rx_overrun;
    logic       rx_frame_err;

    modport master (
        output outr, fgo, fgi, rxd,
        input  fgo_set, fgi_set, inpr_data, inpr_ld, txd,
               rx_overrun, rx_frame_err
    );

    modport slave (
        input  outr, fgo, fgi, rxd,
        output fgo_set, fgi_set, inpr_data, inpr_ld, txd,
               rx_overrun, rx_frame_err
    );
endinterface

// File: rtl/mano_io_term.sv
// mano_io_term -- device end of the Mano OUTR/FGO and INPR/FGI handshakes,
// serialising characters onto txd and deserialising rxd, both 8N1 LSB first.
//
// Parameters:
//   CLKS_PER_BIT  mclk cycles per serial bit (4..1024)
// Ports:
//   mclk  single clock, rising edge
//   mrst  synchronous active-high reset
//   io    mano_io_term_if.slave (CPU flags/registers and serial lines)
//
// Transmit and receive are two independent FSMs, each written as state
// register / next-state logic / output logic plus a datapath register block.
module mano_io_term #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic          mclk,
    input  logic          mrst,
    mano_io_term_if.slave io
);

    localparam int unsigned    CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  LAST      = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    // ------------------------------------------------------------------
    // Transmit
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_INIT,
        TX_WAIT,
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        TX_DONE
    } tx_state_t;

    tx_state_t       tx_state;
    tx_state_t       tx_next;
    logic [CW-1:0]   tx_cnt;
    logic [2:0]      tx_bit;
    logic [7:0]      tx_shreg;
    logic            tx_bit_end;

    assign tx_bit_end = (tx_cnt == LAST);

    always_ff @(posedge mclk) begin
        if (mrst) begin
            tx_state <= TX_INIT;
        end else begin
            tx_state <= tx_next;
        end
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_INIT:  tx_next = TX_WAIT;
            TX_WAIT:  if (io.fgo)  tx_next = TX_IDLE;
            TX_IDLE:  if (!io.fgo) tx_next = TX_START;
            TX_START: if (tx_bit_end) tx_next = TX_DATA;
            TX_DATA:  if (tx_bit_end && (tx_bit == 3'd7)) tx_next = TX_STOP;
            TX_STOP:  if (tx_bit_end) tx_next = TX_DONE;
            TX_DONE:  tx_next = TX_WAIT;
            default:  tx_next = TX_INIT;
        endcase
    end

    // The byte is captured once in TX_IDLE and only shifted afterwards, so
    // outr/fgo activity during the frame cannot alter what goes on the line.
    always_ff @(posedge mclk) begin
        if (mrst) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shreg <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_cnt <= '0;
                    tx_bit <= '0;
                    if (!io.fgo) begin
                        tx_shreg <= io.outr;
                    end
                end
                TX_START, TX_DATA, TX_STOP: begin
                    if (tx_bit_end) begin
                        tx_cnt <= '0;
                        if (tx_state == TX_DATA) begin
                            tx_shreg <= {1'b0, tx_shreg[7:1]};
                            tx_bit   <= tx_bit + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: begin
                    tx_cnt <= '0;
                    tx_bit <= '0;
                end
            endcase
        end
    end

    // Outputs are forced quiet while mrst is high so a frame or pulse in
    // flight never leaks a partial pulse during reset.
    always_comb begin
        io.txd     = 1'b1;
        io.fgo_set = 1'b0;
        if (!mrst) begin
            case (tx_state)
                TX_START:         io.txd     = 1'b0;
                TX_DATA:          io.txd     = tx_shreg[0];
                TX_INIT, TX_DONE: io.fgo_set = 1'b1;
                default:          io.txd     = 1'b1;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_DELIVER
    } rx_state_t;

    rx_state_t       rx_state;
    rx_state_t       rx_next;
    logic [1:0]      rx_sync;
    logic            rx_s;
    logic            rx_prev;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shreg;
    logic [7:0]      inpr_reg;
    logic            overrun_reg;
    logic            ferr_reg;
    logic            rx_bit_end;
    logic            rx_half;
    logic            deliver_ok;

    assign rx_s       = rx_sync[1];
    assign rx_bit_end = (rx_cnt == LAST);
    assign rx_half    = (rx_cnt == HALF_LAST);

    always_ff @(posedge mclk) begin
        if (mrst) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:    if (rx_prev && !rx_s) rx_next = RX_START;
            RX_START:   if (rx_half) rx_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:    if (rx_bit_end && (rx_bit == 3'd7)) rx_next = RX_STOP;
            RX_STOP:    if (rx_bit_end) rx_next = rx_s ? RX_DELIVER : RX_IDLE;
            RX_DELIVER: rx_next = RX_IDLE;
            default:    rx_next = RX_IDLE;
        endcase
    end

    // Synchroniser and edge-detect history reset to the idle (high) line
    // level so leaving reset never looks like a start edge.
    always_ff @(posedge mclk) begin
        if (mrst) begin
            rx_sync     <= 2'b11;
            rx_prev     <= 1'b1;
            rx_cnt      <= '0;
            rx_bit      <= '0;
            rx_shreg    <= '0;
            inpr_reg    <= '0;
            overrun_reg <= 1'b0;
            ferr_reg    <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[0], io.rxd};
            rx_prev <= rx_s;
            case (rx_state)
                RX_START: begin
                    rx_bit <= '0;
                    if (rx_half) begin
                        rx_cnt <= '0;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_bit_end) begin
                        rx_cnt   <= '0;
                        rx_shreg <= {rx_s, rx_shreg[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_bit_end) begin
                        rx_cnt <= '0;
                        if (!rx_s) begin
                            ferr_reg <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DELIVER: begin
                    rx_cnt <= '0;
                    if (io.fgi) begin
                        overrun_reg <= 1'b1;
                    end else begin
                        inpr_reg <= rx_shreg;
                    end
                end
                default: begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                end
            endcase
        end
    end

    // inpr_data shows the new byte in the same cycle as inpr_ld so the CPU
    // loads the fresh value; inpr_reg then holds it until the next delivery.
    always_comb begin
        deliver_ok      = (rx_state == RX_DELIVER) && !io.fgi && !mrst;
        io.inpr_ld      = deliver_ok;
        io.fgi_set      = deliver_ok;
        io.inpr_data    = deliver_ok ? rx_shreg : inpr_reg;
        io.rx_overrun   = overrun_reg;
        io.rx_frame_err = ferr_reg;
    end

endmodule

// File: tb/tb_mano_io_term.sv
// tb_mano_io_term -- directed bench for mano_io_term with a frame-level
// reference model compared against every output on every cycle, plus
// hand-computed literal expectations at key points.
module tb_mano_io_term;

    localparam int N    = 16;
    localparam int HALF = N / 2;
    localparam int HMAX = 8192;

    logic mclk;
    logic mrst;
    mano_io_term_if io();

    mano_io_term #(.CLKS_PER_BIT(N)) dut (
        .mclk (mclk),
        .mrst (mrst),
        .io   (io)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the transmitter is a frame position counter over a
    // 10-bit {stop,data,start} word; the receiver works from a recorded
    // history of the line and decides each frame from sample times.
    // ------------------------------------------------------------------
    bit         r_hist  [HMAX];
    bit         rst_hist[HMAX];
    bit         m_init;
    bit         m_armed;
    int         m_t = -1;
    logic [9:0] m_frame;
    bit         rx_busy;
    int         rx_d;
    int         rx_del = -1;
    logic [7:0] rx_byte;
    logic [7:0] m_inpr;
    bit         m_ovr;
    bit         m_ferr;

    // Line level as seen after the two-stage synchroniser.
    function automatic bit rxs(input int c);
        if (c < 2) return 1'b1;
        if (rst_hist[c-1] || rst_hist[c-2]) return 1'b1;
        return r_hist[c-2];
    endfunction

    always @(posedge mclk) begin
        r_hist[cyc]   = io.rxd;
        rst_hist[cyc] = mrst;
        if (mrst) begin
            m_init  = 1'b1;
            m_armed = 1'b0;
            m_t     = -1;
            rx_busy = 1'b0;
            rx_del  = -1;
            m_inpr  = 8'h00;
            m_ovr   = 1'b0;
            m_ferr  = 1'b0;
        end else begin
            if (m_init) begin
                m_init  = 1'b0;
                m_armed = 1'b0;
            end else if (m_t >= 0) begin
                if (m_t == 10 * N) begin
                    m_t     = -1;
                    m_armed = 1'b0;
                end else begin
                    m_t++;
                end
            end else if (!m_armed) begin
                if (io.fgo) m_armed = 1'b1;
            end else if (!io.fgo) begin
                m_t     = 0;
                m_frame = {1'b1, io.outr, 1'b0};
            end

            if (rx_busy) begin
                if (cyc == rx_d + HALF) begin
                    if (rxs(cyc)) rx_busy = 1'b0;
                end else if (cyc == rx_d + HALF + 9 * N) begin
                    for (int i = 0; i < 8; i++)
                        rx_byte[i] = rxs(rx_d + HALF + N * (i + 1));
                    if (!rxs(cyc)) begin
                        m_ferr  = 1'b1;
                        rx_busy = 1'b0;
                    end else begin
                        rx_del = cyc + 1;
                    end
                end else if (cyc == rx_del) begin
                    rx_busy = 1'b0;
                    rx_del  = -1;
                    if (io.fgi) m_ovr = 1'b1;
                    else        m_inpr = rx_byte;
                end
            end else if (rxs(cyc - 1) && !rxs(cyc)) begin
                rx_busy = 1'b1;
                rx_d    = cyc;
                rx_del  = -1;
            end
        end
        cyc++;
    end

    // Per-cycle comparison against the model.
    logic       e_txd, e_fgo_set, e_dlv;
    logic [7:0] e_data;
    always @(negedge mclk) begin
        if (cyc > 0) begin
            e_txd     = (!mrst && m_t >= 0 && m_t < 10 * N) ? m_frame[m_t / N] : 1'b1;
            e_fgo_set = !mrst && (m_init || m_t == 10 * N);
            e_dlv     = !mrst && rx_busy && (cyc == rx_del) && !io.fgi;
            e_data    = e_dlv ? rx_byte : m_inpr;
            check("txd",          io.txd,          e_txd);
            check("fgo_set",      io.fgo_set,      e_fgo_set);
            check("inpr_ld",      io.inpr_ld,      e_dlv);
            check("fgi_set",      io.fgi_set,      e_dlv);
            check("inpr_data",    io.inpr_data,    e_data);
            check("rx_overrun",   io.rx_overrun,   m_ovr);
            check("rx_frame_err", io.rx_frame_err, m_ferr);
        end
    end

    // Pulse bookkeeping for the literal latency checks.
    int fs_cyc = -1;
    int ld_cyc = -1;
    int ld_cnt = 0;
    always @(negedge mclk) begin
        if (io.fgo_set === 1'b1) fs_cyc = cyc;
        if (io.inpr_ld === 1'b1) begin
            ld_cyc = cyc;
            ld_cnt++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic goto_cycle(input int c);
        while (cyc < c) begin
            @(posedge mclk);
            #1;
        end
    endtask

    task automatic at_neg;
        @(negedge mclk);
    endtask

    task automatic send_rx(input logic [7:0] d, input bit stop);
        int s;
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        s  = cyc;
        for (int k = 0; k < 10; k++) begin
            io.rxd = fr[k];
            goto_cycle(s + N * (k + 1));
        end
        io.rxd = 1'b1;
    endtask

    task automatic tx_frame(input logic [7:0] d, output int first);
        io.fgo = 1'b1;
        goto_cycle(cyc + 2);
        io.outr = d;
        io.fgo  = 1'b0;
        first   = cyc + 1;
        goto_cycle(first + 10 * N + 5);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1);
    end

    int seq_a5[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int first, s, ld0, x;

    initial begin
        mrst    = 1'b1;
        io.outr = 8'h00;
        io.fgo  = 1'b0;
        io.fgi  = 1'b0;
        io.rxd  = 1'b1;

        // Reset for two cycles; init pulse on the first cycle after release.
        goto_cycle(2);
        mrst = 1'b0;
        at_neg;
        check("init_fgo_set", io.fgo_set, 1'b1);
        check("init_txd", io.txd, 1'b1);
        goto_cycle(3);
        at_neg;
        check("init_fgo_set_clr", io.fgo_set, 1'b0);
        goto_cycle(33);
        at_neg;
        check("no_tx_before_fgo1", io.txd, 1'b1);

        // TX 0xA5, with outr/fgo disturbed mid-frame.
        io.fgo = 1'b1;
        goto_cycle(36);
        io.outr = 8'hA5;
        io.fgo  = 1'b0;
        first   = cyc + 1;
        for (int k = 0; k < 10; k++) begin
            goto_cycle(first + N * k + HALF);
            at_neg;
            check("a5_bit", io.txd, seq_a5[k][0]);
            if (k == 5) begin
                goto_cycle(cyc + 1);
                io.outr = 8'hFF;
                io.fgo  = 1'b1;
                goto_cycle(cyc + 3);
                io.fgo  = 1'b0;
            end
        end
        goto_cycle(first + 10 * N + 5);
        check("a5_fgo_set_latency", fs_cyc - first, 160);
        goto_cycle(first + 200);
        at_neg;
        check("a5_no_retransmit", io.txd, 1'b1);

        // RX 0x3C with fgi=0.
        goto_cycle(cyc + 5);
        ld0 = ld_cnt;
        s   = cyc;
        send_rx(8'h3C, 1'b1);
        goto_cycle(cyc + 5);
        check("rx3c_latency", ld_cyc - s, 155);
        check("rx3c_data", io.inpr_data, 8'h3C);
        check("rx3c_ld_count", ld_cnt - ld0, 1);

        // RX 0x55 with fgi=1: overrun, byte dropped.
        io.fgi = 1'b1;
        goto_cycle(cyc + 10);
        ld0 = ld_cnt;
        send_rx(8'h55, 1'b1);
        goto_cycle(cyc + 5);
        at_neg;
        check("ovr_no_ld", ld_cnt - ld0, 0);
        check("ovr_data_held", io.inpr_data, 8'h3C);
        check("ovr_flag", io.rx_overrun, 1'b1);
        io.fgi = 1'b0;

        // Stop bit 0: frame error, no delivery.
        goto_cycle(cyc + 10);
        ld0 = ld_cnt;
        send_rx(8'h81, 1'b0);
        goto_cycle(cyc + 20);
        at_neg;
        check("ferr_flag", io.rx_frame_err, 1'b1);
        check("ferr_no_ld", ld_cnt - ld0, 0);
        check("ovr_sticky", io.rx_overrun, 1'b1);

        // Four-cycle glitch, then a good 0x96.
        ld0 = ld_cnt;
        io.rxd = 1'b0;
        goto_cycle(cyc + 4);
        io.rxd = 1'b1;
        goto_cycle(cyc + 40);
        at_neg;
        check("glitch_no_ld", ld_cnt - ld0, 0);
        check("glitch_data_held", io.inpr_data, 8'h3C);
        goto_cycle(cyc + 1);
        s = cyc;
        send_rx(8'h96, 1'b1);
        goto_cycle(cyc + 5);
        check("rx96_latency", ld_cyc - s, 155);
        check("rx96_data", io.inpr_data, 8'h96);

        // Simultaneous TX 0x3A and RX 0xC3.
        goto_cycle(cyc + 5);
        fork
            tx_frame(8'h3A, first);
            send_rx(8'hC3, 1'b1);
        join
        goto_cycle(cyc + 5);
        check("sim_rx_data", io.inpr_data, 8'hC3);
        check("sim_tx_latency", fs_cyc - first, 160);

        // Reset during TX data bit 4.
        io.fgo = 1'b1;
        goto_cycle(cyc + 2);
        io.outr = 8'h5A;
        io.fgo  = 1'b0;
        first   = cyc + 1;
        goto_cycle(first + 5 * N + 5);
        mrst = 1'b1;
        x    = cyc;
        goto_cycle(x + 1);
        at_neg;
        check("rst_txd", io.txd, 1'b1);
        check("rst_fgo_set", io.fgo_set, 1'b0);
        goto_cycle(x + 2);
        mrst = 1'b0;
        at_neg;
        check("rst_release_fgo_set", io.fgo_set, 1'b1);
        check("rst_ovr_clr", io.rx_overrun, 1'b0);
        check("rst_ferr_clr", io.rx_frame_err, 1'b0);
        check("rst_data_clr", io.inpr_data, 8'h00);
        goto_cycle(x + 3);
        at_neg;
        check("rst_fgo_set_clr", io.fgo_set, 1'b0);
        goto_cycle(cyc + 30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mano_io_term.md
MANO_IO_TERM -- requirements
Module: mano_io_term

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, mclk cycles per serial bit; legal range 4..1024.
REQ-002 mclk  input  1  single clock; all state changes on rising edge.
REQ-003 mrst  input  1  reset, synchronous, active-high.
REQ-004 outr  input  8  CPU OUTR register value.
REQ-005 fgo  input  1  CPU FGO flag (0 = new character pending).
REQ-006 fgo_set  output  1  one-cycle pulse; CPU loads FGO=1.
REQ-007 fgi  input  1  CPU FGI flag (1 = INPR not yet consumed).
REQ-008 fgi_set  output  1  one-cycle pulse; CPU loads FGI=1.
REQ-009 inpr_data  output  8  received character for CPU INPR.
REQ-010 inpr_ld  output  1  one-cycle pulse; CPU loads INPR from inpr_data.
REQ-011 txd  output  1  serial out, idle high, 8N1, LSB first.
REQ-012 rxd  input  1  serial in, asynchronous, 8N1, LSB first.
REQ-013 rx_overrun  output  1  sticky: character dropped because fgi=1.
REQ-014 rx_frame_err  output  1  sticky: stop bit sampled 0.

Function -- transmit (device end of OUTR/FGO handshake)
REQ-015 TX states: TX_INIT, TX_WAIT, TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE.
REQ-016 TX_INIT: lasts one cycle, asserts fgo_set, goes to TX_WAIT.
REQ-017 TX_WAIT: stay until fgo=1, then TX_IDLE; prevents retransmission of the same character.
REQ-018 TX_IDLE: on fgo=0, latch outr into shift register, go to TX_START; txd low from the next cycle.
REQ-019 TX_START drives txd=0; TX_DATA drives bits 0..7 in order; TX_STOP drives txd=1; each bit lasts exactly CLKS_PER_BIT cycles.
REQ-020 TX_DONE: one cycle after the stop bit ends; fgo_set=1, txd=1, then TX_WAIT.
REQ-021 The latched byte is unaffected by changes to outr or fgo during the frame.
REQ-022 Frame length from first txd=0 cycle to fgo_set pulse: exactly 10*CLKS_PER_BIT cycles.

Function -- receive (device end of INPR/FGI handshake)
REQ-023 rxd passes through a 2-flop synchronizer before any use; the synchronizer resets to 1.
REQ-024 RX states: RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_DELIVER.
REQ-025 RX_IDLE: a synchronized 1->0 transition enters RX_START.
REQ-026 RX_START: sample at CLKS_PER_BIT/2 (floor); 1 = glitch, return to RX_IDLE with no flag change; 0 = RX_DATA.
REQ-027 RX_DATA: sample 8 bits at CLKS_PER_BIT intervals from the start-bit midpoint, LSB first.
REQ-028 RX_STOP: sample one CLKS_PER_BIT later; 0 sets rx_frame_err, discards the byte, and returns to RX_IDLE.
REQ-029 RX_DELIVER (valid stop, one cycle): if fgi=0, update inpr_data and assert inpr_ld and fgi_set in the same cycle.
REQ-030 RX_DELIVER: if fgi=1, inpr_data is held, no pulses are issued, and rx_overrun is set.
REQ-031 After RX_DELIVER, the next state is RX_IDLE; a new start edge is accepted from the following cycle.
REQ-032 inpr_data holds its value between deliveries.
REQ-033 TX and RX are fully independent; simultaneous activity has no interaction.
REQ-034 rx_overrun and rx_frame_err clear only on mrst.

Reset
REQ-035 While mrst=1: txd=1, fgo_set=0, fgi_set=0, inpr_ld=0, inpr_data=0x00, rx_overrun=0, rx_frame_err=0; all counters 0; TX state TX_INIT, RX state RX_IDLE.
REQ-036 The first cycle after mrst falls is TX_INIT, which pulses fgo_set; this gives the CPU FGO=1 after reset.
REQ-037 mrst during any frame aborts it at the next edge with no partial pulse; txd=1 on that edge.

Verification (CLKS_PER_BIT=16)
REQ-038 Reset: mrst=1 for 2 cycles, then 0 -> txd=1, fgo_set=1 for exactly the first cycle after release; with fgo held 0, no transmission until fgo=1 has been seen.
REQ-039 TX 0xA5: fgo 1->0 with outr=0xA5 -> txd sequence 0,1,0,1,0,0,1,0,1,1 at 16 cycles per bit; fgo_set pulse at cycle 160; outr changed to 0xFF mid-frame has no effect.
REQ-040 RX 0x3C with fgi=0 -> inpr_data=0x3C, inpr_ld=fgi_set=1 for one cycle, 9.5 bit-times plus 2-3 cycles after the start edge.
REQ-041 RX 0x55 with fgi=1 -> no inpr_ld or fgi_set, inpr_data unchanged, rx_overrun=1 and sticky.
REQ-042 RX with stop bit 0 -> rx_frame_err=1, no pulses; a 4-cycle low glitch on rxd -> no state change.
REQ-043 mrst asserted at TX bit 4 -> txd=1 next edge, no fgo_set during reset, fgo_set init pulse after release.
